// File: rtl/dot_result_line_packer_pkg.sv
// rtl/dot_result_line_packer_pkg.sv - shared width constants and state enums for the line packer
package dot_result_line_packer_pkg;

  localparam int CACHE_WIDTH = 512;
  localparam int DATA_WIDTH  = 32;
  localparam int DATA_SIZE   = CACHE_WIDTH / DATA_WIDTH;
  localparam int LANE_IDX_W  = $clog2(DATA_SIZE);

  typedef enum logic {
    FILLING  = 1'b0,
    COMPLETE = 1'b1
  } fill_state_e;

  typedef enum logic {
    EMPTY = 1'b0,
    VALID = 1'b1
  } slot_state_e;

endpackage

// File: rtl/dot_result_line_packer_out_slot.sv
// rtl/dot_result_line_packer_out_slot.sv - single-entry valid/ready output register with accepted-line counter
module packer_out_slot
  import dot_result_line_packer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic [CACHE_WIDTH-1:0] load_data_i,
  input  logic [DATA_SIZE-1:0]   load_mask_i,
  input  logic                   ready_i,
  output logic                   free_o,
  output logic                   valid_o,
  output logic [CACHE_WIDTH-1:0] data_o,
  output logic [DATA_SIZE-1:0]   mask_o,
  output logic [31:0]            lines_out_o
);

  slot_state_e            state_q, state_d;
  logic [CACHE_WIDTH-1:0] data_q, data_d;
  logic [DATA_SIZE-1:0]   mask_q, mask_d;
  logic [31:0]            lines_q, lines_d;
  logic                   handshake;

  assign valid_o     = (state_q == VALID);
  assign handshake   = valid_o && ready_i;
  // Free when empty or draining this cycle, so a load can replace the outgoing line.
  assign free_o      = !valid_o || ready_i;
  assign data_o      = data_q;
  assign mask_o      = mask_q;
  assign lines_out_o = lines_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    lines_d = lines_q;
    if (handshake) begin
      lines_d = lines_q + 32'd1;
    end
    if (load_i) begin
      state_d = VALID;
      data_d  = load_data_i;
      mask_d  = load_mask_i;
    end else if (handshake) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      mask_q  <= '0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      lines_q <= lines_d;
    end
  end

endmodule

// File: rtl/dot_result_line_packer.sv
// rtl/dot_result_line_packer.sv - packs the dot-product result stream into cache lines, double-buffered
module dot_result_line_packer
  import dot_result_line_packer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   flush,
  output logic                   line_valid,
  output logic [CACHE_WIDTH-1:0] line_data,
  output logic [DATA_SIZE-1:0]   line_mask,
  input  logic                   line_ready,
  output logic                   overflow,
  output logic [31:0]            lines_out,
  output logic                   busy
);

  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(DATA_SIZE - 1);

  fill_state_e            fill_q, fill_d;
  logic [LANE_IDX_W-1:0]  lane_q, lane_d;
  logic [CACHE_WIDTH-1:0] buf_q, buf_d, wr_buf, commit_buf;
  logic [DATA_SIZE-1:0]   mask_q, mask_d, wr_mask, commit_mask;
  logic                   overflow_q, overflow_d;
  logic                   commit, slot_free;

  always_comb begin
    fill_d      = fill_q;
    lane_d      = lane_q;
    buf_d       = buf_q;
    mask_d      = mask_q;
    overflow_d  = overflow_q;
    wr_buf      = buf_q;
    wr_mask     = mask_q;
    commit      = 1'b0;
    commit_buf  = buf_q;
    commit_mask = mask_q;
    case (fill_q)
      FILLING: begin
        if (in_valid) begin
          wr_buf[lane_q*DATA_WIDTH +: DATA_WIDTH] = in_data;
          wr_mask[lane_q]                         = 1'b1;
        end
        if ((in_valid && lane_q == LAST_LANE) || (flush && wr_mask != '0)) begin
          commit_buf  = wr_buf;
          commit_mask = wr_mask;
          if (slot_free) begin
            commit = 1'b1;
            buf_d  = '0;
            mask_d = '0;
            lane_d = '0;
          end else begin
            fill_d = COMPLETE;
            buf_d  = wr_buf;
            mask_d = wr_mask;
          end
        end else begin
          buf_d  = wr_buf;
          mask_d = wr_mask;
          if (in_valid) begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      COMPLETE: begin
        // A word arriving on the commit cycle starts the next line in lane 0; flush is ignored here.
        if (slot_free) begin
          commit = 1'b1;
          fill_d = FILLING;
          buf_d  = '0;
          mask_d = '0;
          lane_d = '0;
          if (in_valid) begin
            buf_d[DATA_WIDTH-1:0] = in_data;
            mask_d[0]             = 1'b1;
            lane_d                = LANE_IDX_W'(1);
          end
        end else if (in_valid) begin
          overflow_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q     <= FILLING;
      lane_q     <= '0;
      buf_q      <= '0;
      mask_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      fill_q     <= fill_d;
      lane_q     <= lane_d;
      buf_q      <= buf_d;
      mask_q     <= mask_d;
      overflow_q <= overflow_d;
    end
  end

  packer_out_slot u_out_slot (
    .clk         (clk),
    .rst         (rst),
    .load_i      (commit),
    .load_data_i (commit_buf),
    .load_mask_i (commit_mask),
    .ready_i     (line_ready),
    .free_o      (slot_free),
    .valid_o     (line_valid),
    .data_o      (line_data),
    .mask_o      (line_mask),
    .lines_out_o (lines_out)
  );

  assign overflow = overflow_q;
  assign busy     = (mask_q != '0) || line_valid;

endmodule

// File: tb/tb_dot_result_line_packer.sv
// tb/tb_dot_result_line_packer.sv - randomized bench for dot_result_line_packer against a line-queue model
module tb_dot_result_line_packer;
  import dot_result_line_packer_pkg::*;

  typedef struct packed {
    logic [CACHE_WIDTH-1:0] data;
    logic [DATA_SIZE-1:0]   mask;
  } line_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic [DATA_WIDTH-1:0]  in_data;
  logic                   flush;
  logic                   line_valid;
  logic [CACHE_WIDTH-1:0] line_data;
  logic [DATA_SIZE-1:0]   line_mask;
  logic                   line_ready;
  logic                   overflow;
  logic [31:0]            lines_out;
  logic                   busy;

  int errors = 0;
  int checks = 0;

  line_t                 mq[$];
  logic [DATA_WIDTH-1:0] cur[DATA_SIZE];
  int                    cur_n;
  bit                    m_ovf;
  logic [31:0]           m_lines;

  dot_result_line_packer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .flush      (flush),
    .line_valid (line_valid),
    .line_data  (line_data),
    .line_mask  (line_mask),
    .line_ready (line_ready),
    .overflow   (overflow),
    .lines_out  (lines_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CACHE_WIDTH-1:0] got, input logic [CACHE_WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic line_t pack_cur();
    line_t l;
    l.data = '0;
    l.mask = '0;
    for (int i = 0; i < cur_n; i++) begin
      l.data[i*DATA_WIDTH +: DATA_WIDTH] = cur[i];
      l.mask[i] = 1'b1;
    end
    return l;
  endfunction

  // Model: mq holds finished lines (head = visible slot, second = held complete buffer), cur the partial line.
  task automatic model_step(input bit iv, input logic [DATA_WIDTH-1:0] d, input bit fl, input bit rdy);
    int  pre;
    bit  hs;
    pre = mq.size();
    hs  = (pre > 0) && rdy;
    if (hs) begin
      void'(mq.pop_front());
      m_lines++;
    end
    if (pre == 2 && !hs) begin
      if (iv) m_ovf = 1'b1;
    end else if (pre == 2) begin
      if (iv) begin
        cur[cur_n] = d;
        cur_n++;
      end
    end else begin
      if (iv) begin
        cur[cur_n] = d;
        cur_n++;
      end
      if (cur_n == DATA_SIZE || (fl && cur_n > 0)) begin
        mq.push_back(pack_cur());
        cur_n = 0;
      end
    end
  endtask

  task automatic compare();
    check("line_valid", line_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      check("line_data", line_data, mq[0].data);
      check("line_mask", line_mask, mq[0].mask);
    end
    check("overflow", overflow, m_ovf);
    check("lines_out", lines_out, m_lines);
    check("busy", busy, (mq.size() > 0) || (cur_n > 0));
  endtask

  task automatic cyc(input bit iv, input logic [DATA_WIDTH-1:0] d, input bit fl, input bit rdy);
    in_valid   = iv;
    in_data    = d;
    flush      = fl;
    line_ready = rdy;
    @(posedge clk);
    model_step(iv, d, fl, rdy);
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    flush      = 1'b0;
    line_ready = 1'b0;
    @(posedge clk);
    mq.delete();
    cur_n   = 0;
    m_ovf   = 1'b0;
    m_lines = '0;
    #1;
    rst = 1'b0;
    check("rst_valid", line_valid, 1'b0);
    check("rst_data", line_data, '0);
    check("rst_mask", line_mask, '0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_lines_out", lines_out, '0);
    check("rst_busy", busy, 1'b0);
  endtask

  initial begin
    cur_n   = 0;
    m_ovf   = 1'b0;
    m_lines = '0;
    do_reset();

    // Full line at full rate, slot ready.
    for (int i = 1; i <= 16; i++) cyc(1'b1, 32'(i), 1'b0, 1'b1);
    check("t1_valid", line_valid, 1'b1);
    check("t1_lane0", line_data[31:0], 32'd1);
    check("t1_lane15", line_data[511:480], 32'd16);
    check("t1_mask", line_mask, 16'hFFFF);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("t1_lines_out", lines_out, 32'd1);
    check("t1_valid_drop", line_valid, 1'b0);

    // Backpressure: 33 words, last one dropped.
    for (int i = 1; i <= 33; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0);
    check("t2_overflow", overflow, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("t2_second_lane0", line_data[31:0], 32'd17);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1);
    check("t2_lines_out", lines_out, 32'd3);
    check("t2_overflow_sticky", overflow, 1'b1);

    // Partial lines via flush alone and flush with the last word.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    check("t3_mask", line_mask, 16'h001F);
    check("t3_upper_zero", line_data[511:160], '0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b1);
    cyc(1'b1, 32'hA4, 1'b1, 1'b1);
    check("t3b_mask", line_mask, 16'h001F);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Flush with nothing buffered, and flush while a complete line is held.
    cyc(1'b0, '0, 1'b1, 1'b1);
    check("t4_empty_flush", line_valid, 1'b0);
    for (int i = 0; i < 32; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1);

    // Handshake on the same cycle the next line completes: no bubble.
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) cyc(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'h30F, 1'b0, 1'b1);
    check("t5_no_bubble", line_valid, 1'b1);
    check("t5_new_lane0", line_data[31:0], 32'h300);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Reset mid-line discards the partial words.
    for (int i = 0; i < 7; i++) cyc(1'b1, 32'h55 + 32'(i), 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0, 1'b1);
    check("t6_lane0", line_data[31:0], 32'h100);
    check("t6_mask", line_mask, 16'hFFFF);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("t6_lines_out", lines_out, 32'd1);
    check("t6_overflow", overflow, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
